// File: rtl/axis_ctrl_pkg.sv
// Shared types for the AXI-Stream frame gate: FSM state encoding and line-counter width helper.
package axis_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        PASS     = 2'd2,
        DROP     = 2'd3
    } gate_state_e;

    function automatic int line_cnt_w(input int lines);
        return $clog2(lines + 1);
    endfunction

endpackage

// File: rtl/axis_frame_tracker.sv
// Counts tlast lines of the frame in flight and flags frame completion or a premature start-of-frame.
// Combinational flags, registered count; no backpressure (the stream has no tready).
module axis_frame_tracker
    import axis_ctrl_pkg::*;
#(
    parameter int LINES = 1080
) (
    input  logic aclk,
    input  logic areset,
    input  logic s_tvalid,
    input  logic s_tlast,
    input  logic s_tuser,
    input  logic waiting,
    input  logic active,
    output logic frame_done,
    output logic early_sof
);

    localparam int LCW = line_cnt_w(LINES);
    localparam logic [LCW-1:0] LAST_LINE = LCW'(LINES - 1);
    localparam logic [LCW-1:0] MAX_LINE  = LCW'(LINES);

    logic [LCW-1:0] line_cnt;
    logic           sof;
    logic           eol;

    assign sof = s_tvalid & s_tuser;
    assign eol = s_tvalid & s_tlast;

    // Any SOF while a frame is open is premature; an SOF that also closes the
    // final line still counts as a new frame rather than a completed one.
    assign early_sof  = active & sof;
    assign frame_done = active & eol & ~s_tuser & (line_cnt >= LAST_LINE);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            line_cnt <= '0;
        end else if (sof & (active | waiting)) begin
            line_cnt <= s_tlast ? LCW'(1) : '0;
        end else if (frame_done) begin
            line_cnt <= '0;
        end else if (active & eol & (line_cnt != MAX_LINE)) begin
            line_cnt <= line_cnt + LCW'(1);
        end
    end

endmodule

// File: rtl/axis_frame_gate.sv
// Frame-granular pass/drop/decimate/one-shot gate for video AXI-Stream; AXIS_FRAME_GATE_STATS_EN adds frame counters.
// 1-cycle registered output; no tready, so nothing is stalled -- beats are forwarded or squashed via m_tvalid.
module axis_frame_gate
    import axis_ctrl_pkg::*;
#(
    parameter int BITWIDTH = 24,
    parameter int LINES    = 1080,
    parameter int SKIP_W   = 4
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [BITWIDTH-1:0] s_tdata,
    input  logic                s_tlast,
    input  logic                s_tuser,
    input  logic                s_tvalid,
    output logic [BITWIDTH-1:0] m_tdata,
    output logic                m_tlast,
    output logic                m_tuser,
    output logic                m_tvalid,
    input  logic                cfg_enable,
    input  logic [SKIP_W-1:0]   cfg_skip,
    input  logic                cfg_oneshot,
    input  logic                oneshot_req,
    output logic [1:0]          sts_state,
    output logic                sts_err_short
`ifdef AXIS_FRAME_GATE_STATS_EN
    ,
    output logic [15:0]         sts_passed,
    output logic [15:0]         sts_dropped
`endif
);

    gate_state_e       state;
    gate_state_e       state_nxt;
    logic [SKIP_W-1:0] phase;
    logic              armed;
    logic              waiting;
    logic              active;
    logic              sof_take;
    logic              pass_now;
    logic              pass_beat;
    logic              frame_done;
    logic              early_sof;

    assign waiting  = (state == WAIT_SOF);
    assign active   = (state == PASS) | (state == DROP);
    assign sof_take = s_tvalid & s_tuser & (waiting | active);

    axis_frame_tracker #(
        .LINES (LINES)
    ) u_tracker (
        .aclk       (aclk),
        .areset     (areset),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tuser    (s_tuser),
        .waiting    (waiting),
        .active     (active),
        .frame_done (frame_done),
        .early_sof  (early_sof)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (cfg_enable) state_nxt = WAIT_SOF;
            WAIT_SOF: if (sof_take) state_nxt = pass_now ? PASS : DROP;
            PASS, DROP: begin
                if (sof_take) begin
                    state_nxt = pass_now ? PASS : DROP;
                end else if (frame_done) begin
                    state_nxt = cfg_enable ? WAIT_SOF : IDLE;
                end
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // The SOF beat itself follows the fresh decision; later beats follow the state.
    always_comb begin
        pass_now  = cfg_oneshot ? armed : (phase == '0);
        pass_beat = sof_take ? pass_now : (state == PASS);
    end

    assign sts_state = state;

    // Phase uses >= so a cfg_skip lowered below the current phase restarts the cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            phase <= '0;
            armed <= 1'b0;
        end else begin
            if (sof_take & ~cfg_oneshot) begin
                phase <= (phase >= cfg_skip) ? '0 : phase + SKIP_W'(1);
            end
            if (sof_take & cfg_oneshot & armed) begin
                armed <= 1'b0;
            end else if (oneshot_req & ~armed) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_tdata       <= '0;
            m_tlast       <= 1'b0;
            m_tuser       <= 1'b0;
            m_tvalid      <= 1'b0;
            sts_err_short <= 1'b0;
        end else begin
            m_tdata       <= s_tdata;
            m_tlast       <= s_tlast;
            m_tuser       <= s_tuser;
            m_tvalid      <= s_tvalid & pass_beat;
            sts_err_short <= early_sof;
        end
    end

`ifdef AXIS_FRAME_GATE_STATS_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sts_passed  <= '0;
            sts_dropped <= '0;
        end else if (sof_take) begin
            if (pass_now) begin
                sts_passed <= sts_passed + 16'd1;
            end else begin
                sts_dropped <= sts_dropped + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_frame_gate.sv
// Directed + randomized bench for axis_frame_gate with a frame-level reference model (LINES = 4).
module tb_axis_frame_gate;
    import axis_ctrl_pkg::*;

    localparam int BW    = 24;
    localparam int LINES = 4;
    localparam int SW    = 4;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [BW-1:0] s_tdata = '0;
    logic          s_tlast = 1'b0;
    logic          s_tuser = 1'b0;
    logic          s_tvalid = 1'b0;
    logic [BW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tuser;
    logic          m_tvalid;
    logic          cfg_enable = 1'b0;
    logic [SW-1:0] cfg_skip = '0;
    logic          cfg_oneshot = 1'b0;
    logic          oneshot_req = 1'b0;
    logic [1:0]    sts_state;
    logic          sts_err_short;
`ifdef AXIS_FRAME_GATE_STATS_EN
    logic [15:0]   sts_passed;
    logic [15:0]   sts_dropped;
`endif

    always #5 aclk = ~aclk;

    axis_frame_gate #(
        .BITWIDTH (BW),
        .LINES    (LINES),
        .SKIP_W   (SW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_tdata       (s_tdata),
        .s_tlast       (s_tlast),
        .s_tuser       (s_tuser),
        .s_tvalid      (s_tvalid),
        .m_tdata       (m_tdata),
        .m_tlast       (m_tlast),
        .m_tuser       (m_tuser),
        .m_tvalid      (m_tvalid),
        .cfg_enable    (cfg_enable),
        .cfg_skip      (cfg_skip),
        .cfg_oneshot   (cfg_oneshot),
        .oneshot_req   (oneshot_req),
        .sts_state     (sts_state),
        .sts_err_short (sts_err_short)
`ifdef AXIS_FRAME_GATE_STATS_EN
        ,
        .sts_passed    (sts_passed),
        .sts_dropped   (sts_dropped)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: frame-level view of the gate.
    bit m_idle, m_inframe, m_pass, m_armed;
    int m_lines, m_nframes, m_np, m_nd;
    bit req_pend;
    int obs_last, obs_sof, obs_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idle = 1; m_inframe = 0; m_pass = 0; m_armed = 0;
        m_lines = 0; m_nframes = 0; m_np = 0; m_nd = 0;
        req_pend = 0;
    endtask

    function automatic logic [1:0] exp_state();
        if (m_idle) return IDLE;
        if (!m_inframe) return WAIT_SOF;
        return m_pass ? PASS : DROP;
    endfunction

    task automatic clear_obs();
        obs_last = 0; obs_sof = 0; obs_err = 0;
    endtask

    // One clock: drive inputs, advance the model, sample outputs 1 time unit after the edge.
    task automatic cyc(input logic v, input logic l, input logic u);
        logic          ev, eerr, sof, armed_before;
        logic [BW-1:0] ed;
        s_tvalid = v; s_tlast = l; s_tuser = u;
        s_tdata = BW'($urandom);
        oneshot_req = req_pend; req_pend = 0;
        ed = s_tdata;
        ev = 0; eerr = 0; sof = v & u; armed_before = m_armed;
        if (m_idle) begin
            if (cfg_enable) m_idle = 0;
        end else if (sof) begin
            eerr = m_inframe;
            if (cfg_oneshot) begin
                m_pass = m_armed;
                m_armed = 0;
            end else begin
                m_pass = (m_nframes % (int'(cfg_skip) + 1)) == 0;
                m_nframes++;
            end
            if (m_pass) m_np++; else m_nd++;
            m_inframe = 1;
            m_lines = l ? 1 : 0;
            ev = m_pass;
        end else if (m_inframe) begin
            ev = v & m_pass;
            if (v & l) begin
                m_lines++;
                if (m_lines == LINES) begin
                    m_inframe = 0;
                    m_lines = 0;
                    if (!cfg_enable) m_idle = 1;
                end
            end
        end
        if (oneshot_req && !armed_before) m_armed = 1;
        @(posedge aclk);
        #1;
        chk("m_tvalid", 32'(m_tvalid), 32'(ev));
        chk("m_tdata", 32'(m_tdata), 32'(ed));
        chk("m_tlast", 32'(m_tlast), 32'(l));
        chk("m_tuser", 32'(m_tuser), 32'(u));
        chk("sts_err_short", 32'(sts_err_short), 32'(eerr));
        chk("sts_state", 32'(sts_state), 32'(exp_state()));
        if (m_tvalid && m_tlast) obs_last++;
        if (m_tvalid && m_tuser) obs_sof++;
        if (sts_err_short) obs_err++;
    endtask

    task automatic idle(input int n);
        logic [1:0] junk;
        for (int i = 0; i < n; i++) begin
            junk = 2'($urandom);
            cyc(1'b0, junk[0], junk[1]);
        end
    endtask

    // Sends nlines lines of 1..3 beats; optional req pulse / enable drop at a given line.
    task automatic frame(input int nlines, input int req_line, input int dis_line, input bit with_sof);
        logic [1:0] junk;
        int nb;
        for (int ln = 0; ln < nlines; ln++) begin
            nb = $urandom_range(1, 3);
            if (ln == req_line) req_pend = 1;
            if (ln == dis_line) cfg_enable = 0;
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    junk = 2'($urandom);
                    cyc(1'b0, junk[0], junk[1]);
                end
                cyc(1'b1, b == nb - 1, with_sof && ln == 0 && b == 0);
            end
        end
    endtask

    task automatic do_reset();
        areset = 1;
        #1;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_err", 32'(sts_err_short), 32'd0);
        chk("rst_state", 32'(sts_state), 32'(IDLE));
        model_reset();
        @(posedge aclk);
        #1;
        areset = 0;
    endtask

    initial begin
        model_reset();
        clear_obs();
        #2;
        do_reset();

        // Continuous pass, skip 0
        cfg_enable = 1; cfg_skip = 0; cfg_oneshot = 0;
        idle(2);
        clear_obs();
        for (int f = 0; f < 3; f++) begin
            frame(LINES, -1, -1, 1);
            idle($urandom_range(0, 2));
        end
        chk("cont_tlasts", 32'(obs_last), 32'd12);
        chk("cont_sofs", 32'(obs_sof), 32'd3);

        // Decimation: 1 of every 3
        do_reset();
        cfg_enable = 1; cfg_skip = 2;
        idle(2);
        clear_obs();
        for (int f = 0; f < 6; f++) frame(LINES, -1, -1, 1);
        chk("decim_sofs", 32'(obs_sof), 32'd2);
        chk("decim_tlasts", 32'(obs_last), 32'd8);

        // Single-shot capture
        do_reset();
        cfg_enable = 1; cfg_skip = 0; cfg_oneshot = 1;
        idle(2);
        clear_obs();
        frame(LINES, -1, -1, 1);
        frame(LINES, 1, -1, 1);
        frame(LINES, 2, -1, 1);
        frame(LINES, -1, -1, 1);
        frame(LINES, -1, -1, 1);
        chk("oneshot_sofs", 32'(obs_sof), 32'd2);

        // Early SOF after 2 lines
        do_reset();
        cfg_enable = 1; cfg_oneshot = 0; cfg_skip = 0;
        idle(2);
        clear_obs();
        frame(2, -1, -1, 1);
        frame(LINES, -1, -1, 1);
        chk("short_err", 32'(obs_err), 32'd1);
        chk("short_tlasts", 32'(obs_last), 32'd6);

        // Enable dropped during line 2 of a passed frame
        clear_obs();
        frame(LINES, -1, 1, 1);
        idle(2);
        chk("dis_state", 32'(sts_state), 32'(IDLE));
        chk("dis_tlasts", 32'(obs_last), 32'd4);
        frame(LINES, -1, -1, 1);
        chk("dis_sofs", 32'(obs_sof), 32'd1);

        // Reset mid-frame, then leftover lines are discarded
        cfg_enable = 1;
        idle(2);
        frame(2, -1, -1, 1);
        do_reset();
        idle(1);
        clear_obs();
        frame(2, -1, -1, 0);
        chk("postrst_tvalid_cnt", 32'(obs_last), 32'd0);
        frame(LINES, -1, -1, 1);
        chk("postrst_tlasts", 32'(obs_last), 32'd4);

        // Randomized run against the model
        do_reset();
        cfg_enable = 1; cfg_oneshot = 0; cfg_skip = SW'($urandom_range(0, 3));
        idle(2);
        for (int f = 0; f < 40; f++) begin
            if (f == 20) cfg_oneshot = 1;
            cfg_enable = ($urandom_range(0, 7) != 0);
            frame($urandom_range(1, LINES), $urandom_range(0, 5), $urandom_range(0, 9), 1);
            idle($urandom_range(0, 2));
        end
`ifdef AXIS_FRAME_GATE_STATS_EN
        chk("stats_passed", 32'(sts_passed), 32'(m_np));
        chk("stats_dropped", 32'(sts_dropped), 32'(m_nd));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
